muldiv_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs 64-bit unsigned multiply (shift-add) and unsigned divide (restoring shift-subtract) on a single shared `add_sub_64bit` instance. It drives the adder's `M` input per step: 0 to add, 1 to subtract. It sits beside the execute-stage ALU and serves MUL/MULHU/DIVU/REMU-class operations with a start/done handshake. One adder pass per cycle; no second adder is instantiated.

---
 rtl/muldiv_seq_ctrl_if.sv | 25 ++
 rtl/muldiv_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the multi-cycle
// multiply/divide sequencer.
interface muldiv_seq_ctrl_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// 64-bit unsigned shift-add multiply / restoring divide on one shared adder.
// Optional macro MULDIV_ZERO_SKIP_EN: zero-operand requests complete in one cycle.
module add_sub_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        m,
  output logic [63:0] sum,
  output logic        cout
);
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b ^ {64{m}}} + {64'b0, m};
  end
endmodule

module muldiv_seq_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic [WIDTH-1:0] bq_q, bq_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] hs;
  logic             msb;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             take;
`ifdef MULDIV_ZERO_SKIP_EN
  logic             skip;
`endif

  // Divide works on {H, L} shifted left by one; multiply feeds H straight in.
  always_comb begin
    hs    = {h_q[62:0], l_q[63]};
    msb   = h_q[63];
    add_a = op_q ? hs : h_q;
  end

  add_sub_64bit u_add_sub (
    .a    (add_a),
    .b    (bq_q),
    .m    (op_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    take    = msb | add_cout;
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    l_d     = l_q;
    bq_d    = bq_q;
    op_d    = op_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef MULDIV_ZERO_SKIP_EN
    skip    = bus.op ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          cnt_d = '0;
          h_d   = '0;
          dbz_d = bus.op & (bus.b == '0);
          if (bus.op) begin
            l_d  = bus.a;
            bq_d = bus.b;
          end else begin
            l_d  = bus.b;
            bq_d = bus.a;
          end
`ifdef MULDIV_ZERO_SKIP_EN
          // Load the final results directly instead of iterating.
          if (skip) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (bus.op) begin
              l_d = '1;
              h_d = bus.a;
            end else begin
              l_d = '0;
            end
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = S_RUN;
          busy_d  = 1'b1;
`endif
        end
      end

      S_RUN: begin
        if (op_q) begin
          if (take) begin
            h_d = add_sum;
            l_d = {l_q[62:0], 1'b1};
          end else begin
            h_d = hs;
            l_d = {l_q[62:0], 1'b0};
          end
        end else if (l_q[0]) begin
          h_d = {add_cout, add_sum[63:1]};
          l_d = {add_sum[0], l_q[63:1]};
        end else begin
          h_d = {1'b0, h_q[63:1]};
          l_d = {h_q[0], l_q[63:1]};
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      bq_q    <= '0;
      op_q    <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      bq_q    <= bq_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_lo   = l_q;
  assign bus.result_hi   = h_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: directed table, random vectors against an
// arithmetic model, and reset/abort sequences.
module tb_muldiv_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_ctrl_if #(.WIDTH(64)) bus_if ();

  muldiv_seq_ctrl #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

`ifdef MULDIV_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] lo;
    logic [63:0] hi;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        dbz;
    int unsigned lat;
    int unsigned busy_n;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[8];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  function automatic bit is_skip(input logic op, input logic [63:0] a, input logic [63:0] b);
    return SKIP_EN && (op ? (b == 64'd0) : ((a == 64'd0) || (b == 64'd0)));
  endfunction

  task automatic issue(input vec_t v, input string name);
    exp_t        e;
    exp_t        got_e;
    int unsigned busy_n;
    bit          got;
    logic [63:0] lo_s;
    logic [63:0] hi_s;
    e.lo     = v.lo;
    e.hi     = v.hi;
    e.dbz    = v.dbz;
    e.lat    = is_skip(v.op, v.a, v.b) ? 1 : 65;
    e.busy_n = is_skip(v.op, v.a, v.b) ? 0 : 64;
    busy_n   = 0;
    got      = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = v.op;
    bus_if.a     = v.a;
    bus_if.b     = v.b;
    sb.push_back(e);
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.busy) busy_n++;
      if (bus_if.done) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        check({name, " latency"}, 64'(cyc), 64'(got_e.lat));
        check({name, " busy_cycles"}, 64'(busy_n), 64'(got_e.busy_n));
        check({name, " busy_at_done"}, 64'(bus_if.busy), 64'd0);
        check({name, " result_lo"}, bus_if.result_lo, got_e.lo);
        check({name, " result_hi"}, bus_if.result_hi, got_e.hi);
        check({name, " div_by_zero"}, 64'(bus_if.div_by_zero), 64'(got_e.dbz));
        lo_s = bus_if.result_lo;
        hi_s = bus_if.result_hi;
        @(negedge clk);
        check({name, " done_pulse"}, 64'(bus_if.done), 64'd0);
        check({name, " hold_lo"}, bus_if.result_lo, lo_s);
        check({name, " hold_hi"}, bus_if.result_hi, hi_s);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no done required done within 200 cycles", name);
      sb.delete();
    end
  endtask

  initial begin
    vec_t        v;
    logic [127:0] p;
    int unsigned done_n;
    int unsigned busy_n;

    tbl[0] = '{1'b0, 64'd3, 64'd5, 64'd15, 64'd0, 1'b0};
    tbl[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[2] = '{1'b1, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
    tbl[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'd3,
               64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0};
    tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 1'b0};
    tbl[5] = '{1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1};
    tbl[6] = '{1'b0, 64'd0, 64'hDEAD_BEEF, 64'd0, 64'd0, 1'b0};
    tbl[7] = '{1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd1, 1'b0};

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus_if.busy), 64'd0);
    check("reset done", 64'(bus_if.done), 64'd0);
    check("reset dbz", 64'(bus_if.div_by_zero), 64'd0);
    check("reset result_lo", bus_if.result_lo, 64'd0);
    check("reset result_hi", bus_if.result_hi, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) issue(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v.op = 1'($urandom_range(0, 1));
      v.a  = {$urandom, $urandom};
      v.b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (v.op == 1'b0) begin
        p    = 128'(v.a) * 128'(v.b);
        v.lo = p[63:0];
        v.hi = p[127:64];
      end else if (v.b == 64'd0) begin
        v.lo = '1;
        v.hi = v.a;
      end else begin
        v.lo = v.a / v.b;
        v.hi = v.a % v.b;
      end
      v.dbz = v.op && (v.b == 64'd0);
      issue(v, $sformatf("rand%0d", i));
    end

    // Abort a multiply with reset; a start pulse mid-run must be ignored.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 1'b0;
    bus_if.a     = 64'd12345;
    bus_if.b     = 64'd678;
    @(posedge clk);
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      bus_if.start = (cyc == 10);
      if (cyc == 10) bus_if.a = 64'd999;
      if (cyc == 29) check("abort busy_before", 64'(bus_if.busy), 64'd1);
      if (cyc == 30) rst = 1'b1;
      if (cyc == 31) begin
        rst = 1'b0;
        check("abort busy", 64'(bus_if.busy), 64'd0);
        check("abort done", 64'(bus_if.done), 64'd0);
        check("abort result_lo", bus_if.result_lo, 64'd0);
        check("abort result_hi", bus_if.result_hi, 64'd0);
      end
    end
    done_n = 0;
    busy_n = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (bus_if.done) done_n++;
      if (bus_if.busy) busy_n++;
    end
    check("abort no_done", 64'(done_n), 64'd0);
    check("abort stays_idle", 64'(busy_n), 64'd0);
    issue('{1'b0, 64'd7, 64'd6, 64'd42, 64'd0, 1'b0}, "after_abort");

    // Start coincident with reset is dropped.
    @(negedge clk);
    rst          = 1'b1;
    bus_if.start = 1'b1;
    bus_if.op    = 1'b0;
    bus_if.a     = 64'd5;
    bus_if.b     = 64'd9;
    @(negedge clk);
    rst          = 1'b0;
    bus_if.start = 1'b0;
    check("rst_start busy", 64'(bus_if.busy), 64'd0);
    @(negedge clk);
    check("rst_start busy_later", 64'(bus_if.busy), 64'd0);
    check("rst_start done", 64'(bus_if.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
